// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR controllers.
package fir_pkg;

    localparam int unsigned NUM_TAP = 10;
    localparam int unsigned COEFF_W = 16;
    localparam int unsigned DIV     = 40;
    localparam int unsigned ADDR_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StDone
    } firState_e;

endpackage

// File: rtl/fir_sample_tick.sv
// Free-running mod-DIV counter; emits a one-cycle sample enable on the last count.
module fir_sample_tick #(
    parameter int unsigned DIV = fir_pkg::DIV
) (
    input  logic iClk_12M,
    input  logic iRsn,
    output logic oEnSample_300k
);
    import fir_pkg::*;

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cntQ, cntD;

    always_comb begin
        cntD = cntQ + 1'b1;
        if (cntQ == LastCnt) begin
            cntD = '0;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign oEnSample_300k = (cntQ == LastCnt);

endmodule

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: host-facing shadow bank, sample-aligned atomic swap into the
// active bank that feeds the datapath.
module fir_coeff_ctrl #(
    parameter int unsigned NUM_TAP = fir_pkg::NUM_TAP,
    parameter int unsigned COEFF_W = fir_pkg::COEFF_W,
    parameter int unsigned DIV     = fir_pkg::DIV
) (
    input  logic                       iClk_12M,
    input  logic                       iRsn,
    input  logic                       iCsnRam,
    input  logic                       iWenRam,
    input  logic [fir_pkg::ADDR_W-1:0] iAddrRam,
    input  logic [COEFF_W-1:0]         iWrDtRam,
    output logic [COEFF_W-1:0]         oRdDtRam,
    input  logic                       iCommit,
    output logic                       oBusy,
    output logic                       oCommitDone,
    output logic                       oEnSample_300k,
    output logic [NUM_TAP*COEFF_W-1:0] oCoeff
);
    import fir_pkg::*;

    localparam logic [ADDR_W-1:0] NumTapAddr = ADDR_W'(NUM_TAP);

    firState_e          stateQ, stateD;
    logic               enSample;
    logic               addrValid;
    logic               hostWr;
    logic               hostRd;
    logic               swapCoeff;
    logic [COEFF_W-1:0] shadowQ [NUM_TAP];
    logic [COEFF_W-1:0] activeQ [NUM_TAP];
    logic [COEFF_W-1:0] rdDtQ;

    fir_sample_tick #(
        .DIV(DIV)
    ) uSampleTick (
        .iClk_12M       (iClk_12M),
        .iRsn           (iRsn),
        .oEnSample_300k (enSample)
    );

    assign addrValid = (iAddrRam < NumTapAddr);
    assign hostWr    = !iCsnRam && !iWenRam && addrValid && (stateQ == StIdle);
    assign hostRd    = !iCsnRam && iWenRam;
    // Swap on the sample edge itself: the datapath latches this sample with the old set.
    assign swapCoeff = (stateQ == StPending) && enSample;

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:    if (iCommit) stateD = StPending;
            StPending: if (enSample) stateD = StDone;
            StDone:    stateD = StIdle;
            default:   stateD = StIdle;
        endcase
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int k = 0; k < int'(NUM_TAP); k++) begin
                shadowQ[k] <= '0;
            end
        end else if (hostWr) begin
            shadowQ[iAddrRam] <= iWrDtRam;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int k = 0; k < int'(NUM_TAP); k++) begin
                activeQ[k] <= '0;
            end
        end else if (swapCoeff) begin
            for (int k = 0; k < int'(NUM_TAP); k++) begin
                activeQ[k] <= shadowQ[k];
            end
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            rdDtQ <= '0;
        end else if (hostRd) begin
            rdDtQ <= addrValid ? shadowQ[iAddrRam] : '0;
        end
    end

    always_comb begin
        oCoeff = '0;
        for (int k = 0; k < int'(NUM_TAP); k++) begin
            oCoeff[k*COEFF_W +: COEFF_W] = activeQ[k];
        end
    end

    assign oRdDtRam       = rdDtQ;
    assign oBusy          = (stateQ != StIdle);
    assign oCommitDone    = (stateQ == StDone);
    assign oEnSample_300k = enSample;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: sample tick, host port, commit timing and reset abort.
module tb_fir_coeff_ctrl;

    localparam int CW = 160;

    logic           iClk_12M = 1'b0;
    logic           iRsn = 1'b0;
    logic           iCsnRam = 1'b1;
    logic           iWenRam = 1'b1;
    logic [3:0]     iAddrRam = '0;
    logic [15:0]    iWrDtRam = '0;
    logic [15:0]    oRdDtRam;
    logic           iCommit = 1'b0;
    logic           oBusy;
    logic           oCommitDone;
    logic           oEnSample_300k;
    logic [159:0]   oCoeff;

    int             nCompared = 0;
    int             nMismatched = 0;
    int             cyc = 0;
    logic [159:0]   exp1;
    logic [159:0]   exp2;

    fir_coeff_ctrl uDut (
        .iClk_12M       (iClk_12M),
        .iRsn           (iRsn),
        .iCsnRam        (iCsnRam),
        .iWenRam        (iWenRam),
        .iAddrRam       (iAddrRam),
        .iWrDtRam       (iWrDtRam),
        .oRdDtRam       (oRdDtRam),
        .iCommit        (iCommit),
        .oBusy          (oBusy),
        .oCommitDone    (oCommitDone),
        .oEnSample_300k (oEnSample_300k),
        .oCoeff         (oCoeff)
    );

    always #5 iClk_12M = ~iClk_12M;

    task automatic checkVal(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic busIdle();
        iCsnRam = 1'b1;
        iWenRam = 1'b1;
        iCommit = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge iClk_12M);
        #1;
        cyc++;
        busIdle();
    endtask

    task automatic runTo(input int n);
        while (cyc < n) nextCycle();
    endtask

    task automatic setWr(input logic [3:0] a, input logic [15:0] d);
        iCsnRam = 1'b0;
        iWenRam = 1'b0;
        iAddrRam = a;
        iWrDtRam = d;
    endtask

    task automatic setRd(input logic [3:0] a);
        iCsnRam = 1'b0;
        iWenRam = 1'b1;
        iAddrRam = a;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, " busy"}, CW'(oBusy), '0);
        checkVal({tag, " done"}, CW'(oCommitDone), '0);
        checkVal({tag, " en"}, CW'(oEnSample_300k), '0);
        checkVal({tag, " rd"}, CW'(oRdDtRam), '0);
        checkVal({tag, " coeff"}, oCoeff, '0);
    endtask

    // Hold reset a few cycles, release just after an edge; that cycle is cycle 0.
    task automatic doReset();
        busIdle();
        iRsn = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (3) @(posedge iClk_12M);
        #1;
        iRsn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        exp1 = '0;
        exp1[0*16 +: 16] = 16'h7FFF;
        exp1[1*16 +: 16] = 16'hABCD;
        exp1[5*16 +: 16] = 16'h1234;
        exp1[9*16 +: 16] = 16'h8000;
        exp2 = exp1;
        exp2[2*16 +: 16] = 16'h0042;

        // Free run: sample pulses only at 39, 79, 119, 159, 199
        doReset();
        for (int c = 0; c < 200; c++) begin
            runTo(c);
            #1;
            checkVal($sformatf("run1 en c%0d", c), CW'(oEnSample_300k), CW'(c % 40 == 39));
            checkVal($sformatf("run1 busy c%0d", c), CW'(oBusy), '0);
            checkVal($sformatf("run1 done c%0d", c), CW'(oCommitDone), '0);
        end
        checkVal("run1 rd", CW'(oRdDtRam), '0);
        checkVal("run1 coeff", oCoeff, '0);

        // Host writes/reads and commit timing
        doReset();
        runTo(0);  setWr(4'd0, 16'h7FFF);
        runTo(1);  setWr(4'd9, 16'h8000);
        runTo(2);  setRd(4'd0);
        runTo(3);  setRd(4'd9); #1;
        checkVal("rd tap0", CW'(oRdDtRam), CW'(16'h7FFF));
        runTo(4);  #1;
        checkVal("rd tap9", CW'(oRdDtRam), CW'(16'h8000));
        checkVal("coeff before commit", oCoeff, '0);
        runTo(5);  setWr(4'd5, 16'h1234);
        runTo(6);  setRd(4'd5);
        runTo(7);  #1;
        checkVal("wr-then-rd tap5", CW'(oRdDtRam), CW'(16'h1234));
        runTo(50); setWr(4'd1, 16'hABCD); iCommit = 1'b1; #1;
        checkVal("busy c50", CW'(oBusy), '0);
        runTo(51); #1;
        checkVal("busy c51", CW'(oBusy), CW'(1'b1));
        runTo(60); iCommit = 1'b1;
        runTo(65); setWr(4'd3, 16'h5555);
        runTo(79); #1;
        checkVal("en c79", CW'(oEnSample_300k), CW'(1'b1));
        checkVal("busy c79", CW'(oBusy), CW'(1'b1));
        checkVal("done c79", CW'(oCommitDone), '0);
        checkVal("coeff c79 old", oCoeff, '0);
        runTo(80); #1;
        checkVal("done c80", CW'(oCommitDone), CW'(1'b1));
        checkVal("busy c80", CW'(oBusy), CW'(1'b1));
        checkVal("coeff c80 new", oCoeff, exp1);
        runTo(81); setRd(4'd3); #1;
        checkVal("done c81", CW'(oCommitDone), '0);
        checkVal("busy c81", CW'(oBusy), '0);
        runTo(82); #1;
        checkVal("pending wr ignored tap3", CW'(oRdDtRam), '0);

        // Commit coincident with a sample pulse waits a full period
        runTo(100); setWr(4'd2, 16'h0042);
        runTo(119); iCommit = 1'b1; #1;
        checkVal("en c119", CW'(oEnSample_300k), CW'(1'b1));
        runTo(120); #1;
        checkVal("busy c120", CW'(oBusy), CW'(1'b1));
        checkVal("done c120", CW'(oCommitDone), '0);
        checkVal("coeff c120 old", oCoeff, exp1);
        runTo(130); setWr(4'd3, 16'h5555);
        runTo(159); #1;
        checkVal("coeff c159 old", oCoeff, exp1);
        checkVal("done c159", CW'(oCommitDone), '0);
        runTo(160); setRd(4'd0); #1;
        checkVal("done c160", CW'(oCommitDone), CW'(1'b1));
        checkVal("coeff c160 new", oCoeff, exp2);
        runTo(161); setRd(4'd3); #1;
        checkVal("busy c161", CW'(oBusy), '0);
        checkVal("rd tap0 c161", CW'(oRdDtRam), CW'(16'h7FFF));
        runTo(162); setRd(4'd2); #1;
        checkVal("rd tap3 c162", CW'(oRdDtRam), '0);
        runTo(163); setRd(4'd12); #1;
        checkVal("rd tap2 c163", CW'(oRdDtRam), CW'(16'h0042));
        runTo(164); #1;
        checkVal("rd addr12", CW'(oRdDtRam), '0);
        runTo(170); setWr(4'd12, 16'h1111);
        runTo(175); iCommit = 1'b1;
        runTo(200); #1;
        checkVal("done c200", CW'(oCommitDone), CW'(1'b1));
        checkVal("coeff after addr12 wr", oCoeff, exp2);

        // Reset while pending aborts the commit
        doReset();
        runTo(0);  setWr(4'd4, 16'h0ABC);
        runTo(45); iCommit = 1'b1;
        runTo(50); setRd(4'd4); #1;
        checkVal("abort busy c50", CW'(oBusy), CW'(1'b1));
        runTo(59); #1;
        checkVal("abort rd c59", CW'(oRdDtRam), CW'(16'h0ABC));
        runTo(60); #1;
        iRsn = 1'b0;
        #1;
        checkAllZero("async reset");
        repeat (2) @(posedge iClk_12M);
        #1;
        iRsn = 1'b1;
        cyc = 0;
        for (int c = 0; c < 100; c++) begin
            runTo(c);
            #1;
            checkVal($sformatf("post-abort en c%0d", c), CW'(oEnSample_300k),
                     CW'(c % 40 == 39));
            checkVal($sformatf("post-abort done c%0d", c), CW'(oCommitDone), '0);
            checkVal($sformatf("post-abort busy c%0d", c), CW'(oBusy), '0);
        end
        checkVal("post-abort coeff", oCoeff, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Controller for the transposed 10-tap FIR multiply/add/shift datapath. It generates the 300 kHz sample enable from the 12 MHz clock and owns the coefficient bank. Coefficients are held as a shadow/active pair, so host writes never reach the datapath mid-stream. A host commit swaps the whole set atomically on a sample boundary; the datapath never sees a partial coefficient set.

## Interface
Parameters:
- NUM_TAP, 10, number of filter taps (coefficient entries)
- COEFF_W, 16, signed coefficient width
- DIV, 40, clock cycles per sample (12 MHz / 300 kHz)

Ports (clock and reset first):
- iClk_12M  in  1  system clock, single clock domain
- iRsn  in  1  asynchronous, active-low reset
- iCsnRam  in  1  host chip select, active low
- iWenRam  in  1  host write enable, active low (1 = read)
- iAddrRam  in  4  coefficient index 0..NUM_TAP-1
- iWrDtRam  in  COEFF_W  host write data (signed)
- oRdDtRam  out  COEFF_W  host read data (shadow bank), registered
- iCommit  in  1  one-cycle pulse: request shadow→active swap
- oBusy  out  1  high while a commit is pending
- oCommitDone  out  1  one-cycle pulse after the swap
- oEnSample_300k  out  1  one-cycle sample enable every DIV cycles
- oCoeff  out  NUM_TAP*COEFF_W  active coefficients, tap k at bits [k*COEFF_W +: COEFF_W]

## Operation
- Sample tick: counter 0..DIV-1, wraps to 0. oEnSample_300k=1 exactly when count==DIV-1.
- Shadow bank: NUM_TAP x COEFF_W registers.
  - Write accepted when iCsnRam=0, iWenRam=0, addr<NUM_TAP and state==IDLE.
  - Read when iCsnRam=0, iWenRam=1. oRdDtRam updates next cycle with shadow[addr], or 0 if addr≥NUM_TAP. oRdDtRam holds its value otherwise.
- Active bank drives oCoeff directly (registers, no combinational path from the host).
- FSM states:
  - IDLE: on iCommit, go to PENDING. A write in the same cycle as iCommit is accepted and is included in the swap.
  - PENDING: host writes are ignored. Extra iCommit pulses are ignored. On an edge where oEnSample_300k=1, copy all shadow entries to active and go to DONE.
  - DONE: oCommitDone=1 for this one cycle, then return to IDLE.
- oBusy = (state != IDLE).
- No arithmetic on coefficient values; entries are copied bit-exact, with sign preserved.

## Timing
- Reset (async assert, sync release): counter=0, FSM=IDLE, both banks=0, oCoeff=0, oRdDtRam=0, oBusy=0, oCommitDone=0, oEnSample_300k=0.
- First oEnSample_300k occurs in cycle DIV-1 after reset release (cycle 39). It then repeats every 40 cycles with no jitter. Commits do not affect the counter.
- Swap edge coincides with the sample-enable edge:
  - the datapath captures the sample on that edge using the OLD coefficients;
  - the new coefficients apply from the next sample.
- Commit latency: iCommit seen at edge t; swap happens at the first sample edge strictly after t. If iCommit arrives in the same cycle as the sample enable, the swap waits one full period (40 cycles).
- oCommitDone is high the cycle after the swap edge. oBusy falls on the same edge that oCommitDone falls.
- Read latency: 1 cycle. Write-then-read of the same address on consecutive cycles returns the new data.
- Reset mid-PENDING aborts the commit: active bank = 0, and no oCommitDone pulse is produced.

## Structure
- Shared package fir_pkg holds:
  - constants NUM_TAP, COEFF_W, DIV, and the address width;
  - the FSM state enum (IDLE, PENDING, DONE), also used by the other FIR controllers.
- One sub-module: fir_sample_tick. It is the mod-DIV counter producing oEnSample_300k and has iClk_12M, iRsn and one output.
- Remainder (banks, host port, FSM) lives in fir_coeff_ctrl. Target is 150–250 lines.

## Test plan
- Reset, then free-run 200 cycles → oEnSample_300k pulses at cycles 39, 79, 119, 159, 199 only; all other outputs stay 0.
- Write 0x7FFF to tap 0, 0x8000 to tap 9, read both back → oRdDtRam = 0x7FFF then 0x8000, one cycle after each read. oCoeff unchanged (all 0).
- Commit at cycle 50 → oBusy=1 at cycles 51–80; swap at edge 79; oCommitDone=1 in cycle 80. oCoeff tap0=0x7FFF, tap9=0x8000 from cycle 80.
- Commit coincident with the sample pulse at cycle 119 → swap at 159, not 119. A write to tap 3 issued at cycle 130 is ignored (shadow and active tap 3 unchanged).
- Read address 12 → oRdDtRam=0. Write to address 12 → no bank change.
- Assert iRsn low at cycle 60 while PENDING → all outputs 0 immediately. After release, no oCommitDone occurs, and the first sample pulse is 39 cycles after release.
